misr_signature_analyzer: RTL and testbench

Output-response analyzer for the ATPG/BIST chain. It sits directly downstream of the 5-bit LFSR pattern generator and the circuit under test (CUT). It compacts one CUT response per valid cycle into a multiple-input signature register (MISR) over a fixed number of patterns. It then compares the final signature against a golden value and reports pass/fail.

---
 rtl/bist_pkg.sv | 23 ++
 rtl/misr_core.sv | 64 ++++++
 rtl/misr_signature_analyzer.sv | 152 +++++++++++++++
 tb/tb_misr_signature_analyzer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST chain (LFSR pattern generator and
// output-response analyzer), so both ends agree on width, taps and run length.
//   bist_state_e       analyzer FSM states
//   BIST_WIDTH         response / signature width
//   BIST_POLY          MISR feedback taps, x^WIDTH term excluded (x^5+x^2+1)
//   BIST_NUM_PATTERNS  responses per run, equal to the 5-bit LFSR period
// -----------------------------------------------------------------------------
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        CHECK = 2'b10,
        DONE  = 2'b11
    } bist_state_e;

    localparam int         BIST_WIDTH        = 5;
    localparam logic [4:0] BIST_POLY         = 5'b00101;
    localparam int         BIST_NUM_PATTERNS = 31;

endpackage : bist_pkg

// File: rtl/misr_core.sv
// -----------------------------------------------------------------------------
// misr_core
// Multiple-input signature register. On each enabled cycle the register
// shifts left one bit, folds the shifted-out MSB back in through POLY, and
// XORs in the new response word.
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset (signature -> 0)
//   clear    synchronous clear to 0; wins over enable
//   enable   absorb data_in this cycle
//   data_in  response word to compact
//   sig_out  current signature (registered)
// -----------------------------------------------------------------------------
module misr_core
    import bist_pkg::*;
#(
    parameter int               WIDTH = BIST_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = BIST_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] sig_out
);

    logic [WIDTH-1:0] sig_r;
    logic [WIDTH-1:0] sig_s;

    // One MISR step: shift, conditional feedback of the old MSB, XOR input.
    function automatic logic [WIDTH-1:0] misr_step(
        input logic [WIDTH-1:0] sig,
        input logic [WIDTH-1:0] din
    );
        logic [WIDTH-1:0] fb_mask;
        fb_mask = sig[WIDTH-1] ? POLY : {WIDTH{1'b0}};
        return {sig[WIDTH-2:0], 1'b0} ^ fb_mask ^ din;
    endfunction

    // Next-signature selection: clear, absorb, or hold.
    always_comb begin
        sig_s = sig_r;
        if (clear) begin
            sig_s = {WIDTH{1'b0}};
        end else if (enable) begin
            sig_s = misr_step(sig_r, data_in);
        end else begin
            sig_s = sig_r;
        end
    end

    // Signature register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_r <= {WIDTH{1'b0}};
        end else begin
            sig_r <= sig_s;
        end
    end

    assign sig_out = sig_r;

endmodule : misr_core

// File: rtl/misr_signature_analyzer.sv
// -----------------------------------------------------------------------------
// misr_signature_analyzer
// Output-response analyzer: compacts NUM_PATTERNS CUT responses into a MISR
// signature, then compares it with a golden value and reports pass/fail.
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset; overrides everything
//   start       one-cycle run start, honoured in IDLE and DONE only
//   resp_valid  resp_in carries a CUT response this cycle (RUN only)
//   resp_in     CUT response word
//   golden_sig  expected signature, sampled in CHECK
//   busy        high in RUN and CHECK
//   done        high in DONE, held until next start or rst
//   pass        signature matched golden_sig; only meaningful while done=1
//   signature   current MISR contents
//   pat_count   responses absorbed in the current run
// -----------------------------------------------------------------------------
module misr_signature_analyzer
    import bist_pkg::*;
#(
    parameter int               WIDTH        = BIST_WIDTH,
    parameter int               NUM_PATTERNS = BIST_NUM_PATTERNS,
    parameter logic [WIDTH-1:0] POLY         = BIST_POLY,
    localparam int              CW           = $clog2(NUM_PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_in,
    input  logic [WIDTH-1:0] golden_sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CW-1:0]    pat_count
);

    // Count value at which the incoming valid response is the final one.
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_PATTERNS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    bist_state_e      state_r;
    bist_state_e      state_s;
    logic [CW-1:0]    pat_count_r;
    logic [CW-1:0]    pat_count_s;
    logic             busy_r;
    logic             busy_s;
    logic             done_r;
    logic             done_s;
    logic             pass_r;
    logic             pass_s;
    logic             clear_s;
    logic             enable_s;
    logic             match_s;
    logic [WIDTH-1:0] sig_s;

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr_core (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_s),
        .enable  (enable_s),
        .data_in (resp_in),
        .sig_out (sig_s)
    );

    assign match_s = (sig_s == golden_sig);

    // Next-state, MISR control, counter and flag logic.
    always_comb begin
        state_s     = state_r;
        clear_s     = 1'b0;
        enable_s    = 1'b0;
        pat_count_s = pat_count_r;
        pass_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    clear_s     = 1'b1;
                    pat_count_s = {CW{1'b0}};
                    state_s     = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // start is deliberately not decoded here.
                if (resp_valid) begin
                    enable_s    = 1'b1;
                    pat_count_s = pat_count_r + CNT_ONE;
                    if (pat_count_r == LAST_CNT) begin
                        state_s = CHECK;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            CHECK: begin
                // Signature is already final here; golden_sig sampled now.
                pass_s  = match_s;
                state_s = DONE;
            end
            DONE: begin
                if (start) begin
                    clear_s     = 1'b1;
                    pat_count_s = {CW{1'b0}};
                    pass_s      = 1'b0;
                    state_s     = RUN;
                end else begin
                    pass_s  = pass_r;
                    state_s = DONE;
                end
            end
            default: begin
                state_s     = IDLE;
                pat_count_s = {CW{1'b0}};
                clear_s     = 1'b1;
            end
        endcase
        busy_s = (state_s == RUN) || (state_s == CHECK);
        done_s = (state_s == DONE);
    end

    // State, counter and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            pat_count_r <= {CW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            pat_count_r <= pat_count_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            pass_r      <= pass_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign signature = sig_s;
    assign pat_count = pat_count_r;

endmodule : misr_signature_analyzer

// File: tb/tb_misr_signature_analyzer.sv
module tb_misr_signature_analyzer;

    localparam int W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default 31-pattern run.
    logic         a_rst = 1'b1, a_start = 1'b0, a_valid = 1'b0;
    logic [W-1:0] a_resp = 5'b00000, a_golden = 5'b00000;
    logic         a_busy, a_done, a_pass;
    logic [W-1:0] a_sig;
    logic [4:0]   a_cnt;

    // Instance B: 2-pattern run for hand-traceable signatures.
    logic         b_rst = 1'b1, b_start = 1'b0, b_valid = 1'b0;
    logic [W-1:0] b_resp = 5'b00000, b_golden = 5'b00000;
    logic         b_busy, b_done, b_pass;
    logic [W-1:0] b_sig;
    logic [1:0]   b_cnt;

    misr_signature_analyzer #(.NUM_PATTERNS(31)) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .resp_valid(a_valid),
        .resp_in(a_resp), .golden_sig(a_golden), .busy(a_busy), .done(a_done),
        .pass(a_pass), .signature(a_sig), .pat_count(a_cnt)
    );

    misr_signature_analyzer #(.NUM_PATTERNS(2)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .resp_valid(b_valid),
        .resp_in(b_resp), .golden_sig(b_golden), .busy(b_busy), .done(b_done),
        .pass(b_pass), .signature(b_sig), .pat_count(b_cnt)
    );

    typedef struct packed {
        logic [W-1:0] sig;
        logic [15:0]  cnt;
        logic         pass;
    } exp_t;

    exp_t a_q[$];
    exp_t b_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for A: compares on each rising edge of done.
    logic a_done_d = 1'b0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (a_done && !a_done_d) begin
            if (a_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL a_unexpected_done: done=1 with empty queue (t=%0t)", $time);
            end else begin
                e = a_q.pop_front();
                check("a_final_sig", {27'd0, a_sig}, {27'd0, e.sig});
                check("a_final_cnt", {27'd0, a_cnt}, {16'd0, e.cnt});
                check("a_final_pass", {31'd0, a_pass}, {31'd0, e.pass});
            end
        end
        a_done_d <= a_done;
    end

    // Scoreboard monitor for B.
    logic b_done_d = 1'b0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (b_done && !b_done_d) begin
            if (b_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL b_unexpected_done: done=1 with empty queue (t=%0t)", $time);
            end else begin
                e = b_q.pop_front();
                check("b_final_sig", {27'd0, b_sig}, {27'd0, e.sig});
                check("b_final_cnt", {30'd0, b_cnt}, {16'd0, e.cnt});
                check("b_final_pass", {31'd0, b_pass}, {31'd0, e.pass});
            end
        end
        b_done_d <= b_done;
    end

    task automatic a_drive(input logic st, input logic v, input logic [W-1:0] d);
        a_start = st; a_valid = v; a_resp = d;
        @(posedge clk); #1;
        a_start = 1'b0; a_valid = 1'b0;
    endtask

    task automatic b_drive(input logic st, input logic v, input logic [W-1:0] d);
        b_start = st; b_valid = v; b_resp = d;
        @(posedge clk); #1;
        b_start = 1'b0; b_valid = 1'b0;
    endtask

    // Full 2-pattern run on B (start issued from IDLE or DONE).
    task automatic b_run(input logic [W-1:0] g, input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] exp_sig, input logic exp_pass);
        b_golden = g;
        b_q.push_back('{sig: exp_sig, cnt: 16'd2, pass: exp_pass});
        b_drive(1'b1, 1'b0, 5'b00000);
        check("b_start_busy", {31'd0, b_busy}, 32'd1);
        check("b_start_done", {31'd0, b_done}, 32'd0);
        check("b_start_pass", {31'd0, b_pass}, 32'd0);
        check("b_start_sig", {27'd0, b_sig}, 32'd0);
        b_drive(1'b0, 1'b1, d0);
        check("b_cnt1", {30'd0, b_cnt}, 32'd1);
        b_drive(1'b0, 1'b1, d1);
        check("b_check_busy", {31'd0, b_busy}, 32'd1);
        check("b_check_done", {31'd0, b_done}, 32'd0);
        b_drive(1'b0, 1'b0, 5'b00000);
        check("b_done_flag", {31'd0, b_done}, 32'd1);
        check("b_done_busy", {31'd0, b_busy}, 32'd0);
    endtask

    // Full 31-pattern all-zero run on A.
    task automatic a_run(input logic [W-1:0] g, input logic exp_pass);
        a_golden = g;
        a_q.push_back('{sig: 5'b00000, cnt: 16'd31, pass: exp_pass});
        a_drive(1'b1, 1'b0, 5'b00000);
        for (int i = 0; i < 30; i++) a_drive(1'b0, 1'b1, 5'b00000);
        check("a_cnt30", {27'd0, a_cnt}, 32'd30);
        a_drive(1'b0, 1'b1, 5'b00000);
        check("a_check_done", {31'd0, a_done}, 32'd0);
        check("a_check_busy", {31'd0, a_busy}, 32'd1);
        check("a_check_cnt", {27'd0, a_cnt}, 32'd31);
        a_drive(1'b0, 1'b0, 5'b00000);
        check("a_done_flag", {31'd0, a_done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state on both instances.
        a_rst = 1'b1; b_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("a_rst_sig", {27'd0, a_sig}, 32'd0);
        check("a_rst_cnt", {27'd0, a_cnt}, 32'd0);
        check("a_rst_flags", {29'd0, a_busy, a_done, a_pass}, 32'd0);
        check("b_rst_sig", {27'd0, b_sig}, 32'd0);
        check("b_rst_flags", {29'd0, b_busy, b_done, b_pass}, 32'd0);
        a_rst = 1'b0; b_rst = 1'b0;

        // resp_valid in IDLE is ignored.
        b_drive(1'b0, 1'b1, 5'b11111);
        check("b_idle_valid_sig", {27'd0, b_sig}, 32'd0);
        check("b_idle_valid_cnt", {30'd0, b_cnt}, 32'd0);

        // Scenarios 2 and 3 (B).
        b_run(5'b00010, 5'b00001, 5'b00000, 5'b00010, 1'b1);
        b_run(5'b00011, 5'b00001, 5'b00000, 5'b00010, 1'b0);
        b_run(5'b00101, 5'b10000, 5'b00000, 5'b00101, 1'b1);

        // resp_valid in DONE is ignored; result held.
        b_drive(1'b0, 1'b1, 5'b11111);
        check("b_done_hold_sig", {27'd0, b_sig}, 32'h05);
        check("b_done_hold_cnt", {30'd0, b_cnt}, 32'd2);
        check("b_done_hold_pass", {31'd0, b_pass}, 32'd1);

        // start + resp_valid together in DONE: only start acts.
        b_golden = 5'b00010;
        b_q.push_back('{sig: 5'b00010, cnt: 16'd2, pass: 1'b1});
        b_drive(1'b1, 1'b1, 5'b11111);
        check("b_restart_sig", {27'd0, b_sig}, 32'd0);
        check("b_restart_cnt", {30'd0, b_cnt}, 32'd0);
        check("b_restart_done", {31'd0, b_done}, 32'd0);
        check("b_restart_pass", {31'd0, b_pass}, 32'd0);
        // Scenario 4: stalls in the middle of the run.
        b_drive(1'b0, 1'b1, 5'b00001);
        b_drive(1'b0, 1'b0, 5'b10101);
        check("b_stall1_cnt", {30'd0, b_cnt}, 32'd1);
        check("b_stall1_sig", {27'd0, b_sig}, 32'd1);
        check("b_stall1_busy", {31'd0, b_busy}, 32'd1);
        b_drive(1'b0, 1'b0, 5'b01010);
        check("b_stall2_cnt", {30'd0, b_cnt}, 32'd1);
        check("b_stall2_busy", {31'd0, b_busy}, 32'd1);
        b_drive(1'b0, 1'b1, 5'b00000);
        b_drive(1'b0, 1'b0, 5'b00000);
        check("b_stall_done", {31'd0, b_done}, 32'd1);

        // Scenario 6a: start during RUN is ignored.
        b_q.push_back('{sig: 5'b00010, cnt: 16'd2, pass: 1'b1});
        b_drive(1'b1, 1'b0, 5'b00000);
        b_drive(1'b0, 1'b1, 5'b00001);
        b_drive(1'b1, 1'b0, 5'b00000);
        check("b_run_start_cnt", {30'd0, b_cnt}, 32'd1);
        check("b_run_start_sig", {27'd0, b_sig}, 32'd1);
        check("b_run_start_busy", {31'd0, b_busy}, 32'd1);
        b_drive(1'b0, 1'b1, 5'b00000);
        b_drive(1'b0, 1'b0, 5'b00000);
        check("b_run_start_done", {31'd0, b_done}, 32'd1);

        // Scenario 1 (A): 31 zero responses, golden 0, then golden 1.
        a_run(5'b00000, 1'b1);
        a_run(5'b00001, 1'b0);

        // Scenario 5: reset mid-run after 10 responses.
        a_drive(1'b1, 1'b0, 5'b00000);
        for (int i = 0; i < 10; i++) a_drive(1'b0, 1'b1, 5'b00001);
        check("a_pre_rst_cnt", {27'd0, a_cnt}, 32'd10);
        a_rst = 1'b1;
        a_drive(1'b1, 1'b1, 5'b00001);
        a_rst = 1'b0;
        check("a_mid_rst_sig", {27'd0, a_sig}, 32'd0);
        check("a_mid_rst_cnt", {27'd0, a_cnt}, 32'd0);
        check("a_mid_rst_flags", {29'd0, a_busy, a_done, a_pass}, 32'd0);
        a_run(5'b00000, 1'b1);

        repeat (3) @(posedge clk);
        #2;
        check("a_queue_empty", a_q.size(), 32'd0);
        check("b_queue_empty", b_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_misr_signature_analyzer
